// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the core fetch/execute sequencer.
package core_sequencer_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 4;

    typedef enum logic [3:0] {
        ST_FETCH_HI = 4'd0,
        ST_FETCH_LO = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC     = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_WB       = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_HALT     = 4'd7,
        ST_FAULT    = 4'd8
    } seq_state_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_SRC2 = 2'd1,
        WB_LOAD = 2'd2
    } wb_sel_t;

    localparam logic [OP_W-1:0] OP_HLT = 4'b0000;
    localparam logic [OP_W-1:0] OP_MOV = 4'b0001;
    localparam logic [OP_W-1:0] OP_ALU = 4'b0010;
    localparam logic [OP_W-1:0] OP_CMP = 4'b0011;
    localparam logic [OP_W-1:0] OP_LDW = 4'b1000;
    localparam logic [OP_W-1:0] OP_STW = 4'b1001;

    // True for states that own the shared memory port.
    function automatic logic is_mem_state(input seq_state_t s);
        return (s == ST_FETCH_HI) || (s == ST_FETCH_LO) ||
               (s == ST_MEM_RD)   || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/core_sequencer_mem_wait_timer.sv
// Counts consecutive unacknowledged request cycles and flags the limit.
module core_sequencer_mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic ack_i,
    output logic expire_c
);

    localparam int unsigned CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             waiting_c;

    assign waiting_c = req_i && !ack_i;

    // Next count: clear on ack or idle, saturating increment while stalled.
    always_comb begin
        cnt_d = cnt_q;
        if (!waiting_c) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the stalled cycle that completes WAIT_LIMIT waits; 0 disables.
    assign expire_c = (WAIT_LIMIT != 0) && waiting_c &&
                      (cnt_q == CNT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer sharing one memory port
// between two-halfword instruction fetch and ldw/stw data accesses.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned WAIT_LIMIT = 8
) (
    input  logic                clk,
    input  logic                _reset,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [INSTR_W-1:0]  instr_word,
    output logic                instr_valid,
    input  logic [OP_W-1:0]     opcode,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   store_data,
    output logic                reg_we,
    output logic [1:0]          wb_sel,
    output logic [DATA_W-1:0]   load_data,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic                fault
);

    seq_state_t           state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]    daddr_q, daddr_d;
    logic [DATA_W-1:0]    sdata_q, sdata_d;
    logic [DATA_W-1:0]    load_q, load_d;

    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic                 instr_valid_q;
    logic                 halted_q;
    logic                 fault_q;

    logic                 reg_we_c;
    wb_sel_t              wb_sel_c;
    logic                 xfer_c;
    logic                 expire_c;

    // An ack only counts while our own request is actually on the port.
    assign xfer_c = mem_req_q && mem_ack;

    // Stall watchdog on the memory handshake.
    core_sequencer_mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (_reset),
        .req_i    (mem_req_q),
        .ack_i    (mem_ack),
        .expire_c (expire_c)
    );

    // Next-state, datapath updates and execute-stage strobes.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        daddr_d  = daddr_q;
        sdata_d  = sdata_q;
        load_d   = load_q;
        reg_we_c = 1'b0;
        wb_sel_c = WB_ALU;

        case (state_q)
            ST_FETCH_HI: begin
                if (xfer_c) begin
                    instr_d[31:16] = mem_rdata;
                    pc_d           = pc_q + 16'd1;
                    state_d        = ST_FETCH_LO;
                end
            end
            ST_FETCH_LO: begin
                if (xfer_c) begin
                    instr_d[15:0] = mem_rdata;
                    pc_d          = pc_q + 16'd1;
                    state_d       = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_MOV: begin
                        reg_we_c = 1'b1;
                        wb_sel_c = WB_SRC2;
                        state_d  = ST_FETCH_HI;
                    end
                    OP_ALU: begin
                        reg_we_c = 1'b1;
                        wb_sel_c = WB_ALU;
                        state_d  = ST_FETCH_HI;
                    end
                    OP_CMP: begin
                        state_d = ST_FETCH_HI;
                    end
                    OP_LDW: begin
                        daddr_d = data_addr;
                        state_d = ST_MEM_RD;
                    end
                    OP_STW: begin
                        daddr_d = data_addr;
                        sdata_d = store_data;
                        state_d = ST_MEM_WR;
                    end
                    OP_HLT: begin
                        state_d = ST_HALT;
                    end
                    default: begin
                        state_d = ST_FETCH_HI;
                    end
                endcase
            end
            ST_MEM_RD: begin
                if (xfer_c) begin
                    load_d  = mem_rdata;
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                reg_we_c = 1'b1;
                wb_sel_c = WB_LOAD;
                state_d  = ST_FETCH_HI;
            end
            ST_MEM_WR: begin
                if (xfer_c) begin
                    state_d = ST_FETCH_HI;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        if (expire_c) begin
            state_d = ST_FAULT;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q <= ST_FETCH_HI;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            daddr_q <= '0;
            sdata_q <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            daddr_q <= daddr_d;
            sdata_q <= sdata_d;
            load_q  <= load_d;
        end
    end

    // Port-side outputs registered from the next state; reset clears the
    // request, so the first fetch request appears one cycle after release.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= RESET_PC;
            mem_wdata_q   <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            mem_req_q     <= is_mem_state(state_d);
            mem_we_q      <= (state_d == ST_MEM_WR);
            mem_addr_q    <= ((state_d == ST_MEM_RD) || (state_d == ST_MEM_WR)) ? daddr_d : pc_d;
            mem_wdata_q   <= sdata_d;
            instr_valid_q <= (state_d == ST_DECODE);
            halted_q      <= (state_d == ST_HALT) || (state_d == ST_FAULT);
            fault_q       <= (state_d == ST_FAULT);
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign instr_word  = instr_q;
    assign instr_valid = instr_valid_q;
    assign reg_we      = reg_we_c;
    assign wb_sel      = wb_sel_c;
    assign load_data   = load_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-instruction vector table plus
// hand-written reset, pc-wrap, halt and wait-timeout sequences.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    localparam logic [15:0] PC0  = 16'h1000;
    localparam logic [15:0] NONE = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] instr_word;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [15:0] data_addr, store_data;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [15:0] load_data, pc;
    logic        halted, fault;

    logic        w_mem_req, w_mem_we, w_instr_valid, w_reg_we, w_halted, w_fault;
    logic [15:0] w_mem_addr, w_mem_wdata, w_load_data, w_pc;
    logic [31:0] w_instr_word;
    logic [1:0]  w_wb_sel;

    int n_chk = 0;
    int n_bad = 0;

    logic [15:0] cur_daddr = NONE;
    logic [15:0] cur_rd    = 16'h0;
    int          cur_delay = 0;
    int          req_run   = 0;
    logic        ack_off   = 1'b0;
    logic [15:0] pc_exp;

    always #5 clk = ~clk;

    core_sequencer #(.RESET_PC(PC0), .WAIT_LIMIT(8)) u_dut (
        .clk(clk), ._reset(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_word(instr_word), .instr_valid(instr_valid),
        .opcode(opcode), .data_addr(data_addr), .store_data(store_data),
        .reg_we(reg_we), .wb_sel(wb_sel), .load_data(load_data),
        .pc(pc), .halted(halted), .fault(fault)
    );

    core_sequencer #(.RESET_PC(16'hFFFF), .WAIT_LIMIT(8)) u_wrap (
        .clk(clk), ._reset(rst_n),
        .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .mem_ack(1'b1), .mem_rdata(16'h0000),
        .instr_word(w_instr_word), .instr_valid(w_instr_valid),
        .opcode(OP_MOV), .data_addr(16'h0000), .store_data(16'h0000),
        .reg_we(w_reg_we), .wb_sel(w_wb_sel), .load_data(w_load_data),
        .pc(w_pc), .halted(w_halted), .fault(w_fault)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] daddr;
        logic [15:0] sdata;
        int          delay;
        logic [15:0] rd;
        int          exp_cyc;
        int          exp_rwe;
        logic [1:0]  exp_wb;
        int          exp_wr;
        int          exp_rdreq;
        logic [15:0] exp_load;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [15:0] fetch_word(input logic [15:0] a);
        if (a == 16'h1000) return 16'h1234;
        if (a == 16'h1001) return 16'h5678;
        return a ^ 16'hC0DE;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory responder: data accesses wait cur_delay cycles, fetches ack at once.
    task automatic drive();
        if (ack_off) mem_ack = 1'b0;
        else if (mem_req && mem_addr == cur_daddr) mem_ack = (req_run >= cur_delay);
        else mem_ack = 1'b1;
        mem_rdata = (mem_addr == cur_daddr && !mem_we) ? cur_rd : fetch_word(mem_addr);
        if (mem_req && !mem_ack) req_run++;
        else req_run = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    // Runs one instruction starting in its first FETCH_HI request cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc, rwe, wr, rdreq;
        logic [1:0]  wb_seen;
        logic [31:0] iv_word;
        logic [15:0] iv_pc, nxt;
        logic stable, overlap, done;
        cyc = 0; rwe = 0; wr = 0; rdreq = 0; wb_seen = 2'd0;
        iv_word = '0; iv_pc = '0; stable = 1'b1; overlap = 1'b0; done = 1'b0;
        nxt = pc_exp + 16'd2;
        opcode = v.op; data_addr = v.daddr; store_data = v.sdata;
        cur_daddr = v.daddr; cur_delay = v.delay; cur_rd = v.rd;
        check($sformatf("v%0d_fetch_addr", idx), {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, pc_exp});
        while (!done && cyc < 40) begin
            cyc++;
            if (reg_we) begin
                rwe++;
                wb_seen = wb_sel;
                if (mem_req) overlap = 1'b1;
            end
            if (instr_valid) begin
                iv_word = instr_word;
                iv_pc   = pc;
            end
            if (mem_req && mem_we) begin
                wr++;
                if (mem_addr !== v.daddr || mem_wdata !== v.sdata) stable = 1'b0;
            end
            if (mem_req && !mem_we && mem_addr == v.daddr) rdreq++;
            tick();
            if (mem_req && !mem_we && mem_addr == nxt) done = 1'b1;
        end
        check($sformatf("v%0d_latency", idx), cyc, v.exp_cyc);
        check($sformatf("v%0d_instr_word", idx), iv_word, {fetch_word(pc_exp), fetch_word(pc_exp + 16'd1)});
        check($sformatf("v%0d_pc_decode", idx), {16'd0, iv_pc}, {16'd0, nxt});
        check($sformatf("v%0d_reg_we_cnt", idx), rwe, v.exp_rwe);
        check($sformatf("v%0d_wb_sel", idx), {30'd0, wb_seen}, {30'd0, v.exp_wb});
        check($sformatf("v%0d_wr_cycles", idx), wr, v.exp_wr);
        check($sformatf("v%0d_wr_stable", idx), {31'd0, stable}, 32'd1);
        check($sformatf("v%0d_rd_cycles", idx), rdreq, v.exp_rdreq);
        check($sformatf("v%0d_load_data", idx), {16'd0, load_data}, {16'd0, v.exp_load});
        check($sformatf("v%0d_no_overlap", idx), {31'd0, overlap}, 32'd0);
        pc_exp = nxt;
        check($sformatf("v%0d_pc_next", idx), {16'd0, pc}, {16'd0, pc_exp});
    endtask

    initial begin
        int n;
        vecs[0] = '{OP_MOV, NONE,    16'h0000, 0, 16'h0000, 4, 1, 2'd1, 0, 0, 16'h0000};
        vecs[1] = '{OP_ALU, NONE,    16'h0000, 0, 16'h0000, 4, 1, 2'd0, 0, 0, 16'h0000};
        vecs[2] = '{OP_CMP, NONE,    16'h0000, 0, 16'h0000, 4, 0, 2'd0, 0, 0, 16'h0000};
        vecs[3] = '{4'h5,   NONE,    16'h0000, 0, 16'h0000, 4, 0, 2'd0, 0, 0, 16'h0000};
        vecs[4] = '{OP_LDW, 16'h0040, 16'h0000, 3, 16'hBEEF, 9, 1, 2'd2, 0, 4, 16'hBEEF};
        vecs[5] = '{OP_STW, 16'h0010, 16'hA5A5, 0, 16'h0000, 5, 0, 2'd0, 1, 0, 16'hBEEF};
        vecs[6] = '{OP_LDW, 16'h0050, 16'h0000, 0, 16'h1357, 6, 1, 2'd2, 0, 1, 16'h1357};
        vecs[7] = '{OP_STW, 16'h0020, 16'h0F0F, 2, 16'h0000, 7, 0, 2'd0, 3, 0, 16'h1357};

        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
        opcode = OP_MOV; data_addr = 16'h0; store_data = 16'h0;
        tick(); tick();

        // Reset state of both instances.
        check("rst_strobes", {26'd0, mem_req, mem_we, instr_valid, reg_we, halted, fault}, 32'd0);
        check("rst_pc", {16'd0, pc}, {16'd0, PC0});
        check("rst_instr_word", instr_word, 32'd0);
        check("rst_load_wb", {14'd0, wb_sel, load_data}, 32'd0);
        check("rst_wrap_all", {w_instr_word ^ {w_mem_wdata, w_load_data}} | {24'd0, w_mem_req, w_mem_we,
              w_instr_valid, w_reg_we, w_halted, w_fault, w_wb_sel}, 32'd0);
        check("rst_wrap_pc", {16'd0, w_pc}, 32'h0000FFFF);

        // pc wrap from 16'hFFFF.
        rst_n = 1'b1;
        tick();
        check("wrap_fetch_hi", {15'd0, w_mem_req, w_mem_addr}, {15'd0, 1'b1, 16'hFFFF});
        tick();
        check("wrap_fetch_lo", {15'd0, w_mem_req, w_mem_addr}, {15'd0, 1'b1, 16'h0000});
        tick();
        check("wrap_decode_pc", {15'd0, w_instr_valid, w_pc}, {15'd0, 1'b1, 16'h0001});

        // Instruction table from a clean start.
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        pc_exp = PC0;
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // hlt: terminal, no further requests, pc frozen.
        opcode = OP_HLT; cur_daddr = NONE;
        n = 0;
        while (!halted && n < 10) begin tick(); n++; end
        check("halt_cycles", n, 4);
        check("halt_flags", {30'd0, halted, fault}, 32'd2);
        n = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (mem_req) n++; end
        check("halt_no_req", n, 0);
        check("halt_pc_frozen", {16'd0, pc}, {16'd0, pc_exp + 16'd2});

        // Wait timeout: ack never arrives.
        ack_off = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_clears_halt", {30'd0, halted, fault}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n = mem_req ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (fault) break;
            if (mem_req) n++;
        end
        check("timeout_req_cycles", n, 8);
        check("timeout_flags", {29'd0, mem_req, halted, fault}, 32'd3);
        n = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (mem_req) n++; end
        check("fault_no_req", n, 0);
        rst_n = 1'b0;
        #1;
        check("rst_clears_fault", {30'd0, halted, fault}, 32'd0);

        // Reset in the middle of FETCH_LO.
        ack_off = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("midfl_state", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h1001});
        check("midfl_partial", instr_word, 32'h12340000);
        #3;
        rst_n = 1'b0;
        #1;
        check("midfl_req_drop", {15'd0, mem_req, pc}, {15'd0, 1'b0, PC0});
        check("midfl_discard", instr_word, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midfl_restart", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, PC0});
        pc_exp = PC0;
        run_vec(vecs[0], 8);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the single-issue core.
- Fetches each 32-bit instruction as two 16-bit words over the shared memory port, then presents the instruction to the decoder.
- Samples the decoded opcode and generates the register-file write strobe and write-back select.
- Arbitrates the same memory port between instruction fetch and ldw/stw data accesses, so fetch and data never overlap.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- WAIT_LIMIT, 8, maximum cycles mem_req may wait for mem_ack before the fault state is entered; 0 disables the check.

Ports:
- clk  in  1  core clock
- _reset  in  1  asynchronous active-low reset
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write (stw), 0 = read
- mem_addr  out  16  word address
- mem_wdata  out  16  store data
- mem_ack  in  1  transfer complete this cycle; may assert in the same cycle as mem_req
- mem_rdata  in  16  read data, valid when mem_ack = 1
- instr_word  out  32  latched instruction to the decoder
- instr_valid  out  1  one-cycle pulse in DECODE
- opcode  in  4  decoder opcode, valid in EXEC
- data_addr  in  16  ldw/stw address (src2 path), valid in EXEC
- store_data  in  16  stw data (dest register), valid in EXEC
- reg_we  out  1  register-file write strobe, one cycle
- wb_sel  out  2  write-back source: ALU, SRC2, LOAD
- load_data  out  16  registered ldw result
- pc  out  16  current fetch address
- halted  out  1  sticky; set in HALT or FAULT
- fault  out  1  sticky; set only in FAULT

Behaviour:
- Reset (async, _reset = 0):
  - State = FETCH_HI; pc = RESET_PC.
  - All strobes 0: mem_req, mem_we, instr_valid, reg_we, halted, fault.
  - instr_word = 0, load_data = 0, wb_sel = ALU, wait counter = 0.
- FETCH_HI:
  - mem_req = 1, mem_we = 0, mem_addr = pc.
  - On mem_ack: instr_word[31:16] <= mem_rdata; pc <= pc+1; go to FETCH_LO.
- FETCH_LO:
  - Same request at the new pc.
  - On mem_ack: instr_word[15:0] <= mem_rdata; pc <= pc+1; go to DECODE.
- DECODE: instr_valid = 1 for exactly one cycle; no memory request; always go to EXEC.
- EXEC: sample opcode.
  - 0001 mov: reg_we = 1, wb_sel = SRC2; go to FETCH_HI.
  - 0010 alu: reg_we = 1, wb_sel = ALU; go to FETCH_HI.
  - 0011 cmp: reg_we = 0; go to FETCH_HI.
  - 1000 ldw: latch data_addr; go to MEM_RD.
  - 1001 stw: latch data_addr and store_data; go to MEM_WR.
  - 0000 hlt: go to HALT.
  - Any other value: treated as nop; go to FETCH_HI.
- MEM_RD:
  - mem_req = 1, mem_we = 0, mem_addr = latched address.
  - On mem_ack: load_data <= mem_rdata; go to WB.
- WB: reg_we = 1, wb_sel = LOAD, one cycle; go to FETCH_HI.
- MEM_WR:
  - mem_req = 1, mem_we = 1, mem_addr and mem_wdata = latched values.
  - On mem_ack: go to FETCH_HI; no reg_we.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until the mem_ack cycle.
  - With mem_ack tied high, each access takes one cycle.
  - Minimum latencies:
    - mov/alu/cmp: 4 cycles.
    - stw: 5 cycles.
    - ldw: 6 cycles.
  - mem_ack outside the FETCH_HI, FETCH_LO, MEM_RD and MEM_WR states is ignored.
- Wait counter:
  - Counts consecutive cycles with mem_req = 1 and mem_ack = 0; clears on mem_ack.
  - When WAIT_LIMIT > 0 and the counter reaches WAIT_LIMIT: go to FAULT, mem_req drops, fault = halted = 1.
- HALT and FAULT:
  - Terminal states; no requests; pc frozen.
  - Exit only by reset.
- Arithmetic and widths:
  - pc increments modulo 2^16 (16'hFFFF -> 16'h0000).
  - No other arithmetic in this block.
- reg_we is never asserted in the same cycle as mem_req.
- Reset asserted mid-access drops mem_req asynchronously; the partially fetched instruction is discarded.

Decomposition:
- Shared types package gains:
  - seq_state_t enum.
  - wb_sel_t enum: ALU = 0, SRC2 = 1, LOAD = 2.
  - Opcode constants OP_HLT, OP_MOV, OP_ALU, OP_CMP, OP_LDW, OP_STW.
- Optional sub-module mem_wait_timer (wait counter plus limit compare). Everything else stays flat.

Test Plan:
- mem_ack tied 1, memory {0x1000: 0x1234, 0x1001: 0x5678}, opcode = 0001 in EXEC:
  - instr_word = 0x12345678 in DECODE.
  - reg_we = 1 with wb_sel = SRC2 at cycle 4.
  - pc = 0x0002; next mem_addr = 0x0002.
  - Run with RESET_PC = 0x1000, so pc reads 0x1002 after the fetch.
- ldw, data_addr = 0x0040, mem_ack delayed 3 cycles, mem_rdata = 0xBEEF:
  - mem_req held 4 cycles with mem_addr stable at 0x0040.
  - load_data = 0xBEEF; reg_we = 1 with wb_sel = LOAD on the next cycle.
- stw, data_addr = 0x0010, store_data = 0xA5A5:
  - One cycle with mem_we = 1, mem_addr = 0x0010, mem_wdata = 0xA5A5.
  - reg_we stays 0; fetch then resumes.
- RESET_PC = 16'hFFFF:
  - Fetch addresses 0xFFFF then 0x0000; pc = 0x0001 at DECODE.
- WAIT_LIMIT = 8, mem_ack held 0:
  - fault = halted = 1 after 8 request cycles; mem_req = 0 thereafter; reset clears both.
- opcode = 0000 → halted = 1, no further mem_req.
- Separate run: _reset pulsed low mid-FETCH_LO → mem_req = 0 immediately, pc = RESET_PC, fetch restarts with FETCH_HI.
